// File: rtl/addsub_exec_unit.sv
// addsub_exec_unit: pipelined integer add/subtract unit for the Tomasulo core.
//   Takes ops from the ADD reservation station over valid/ready, computes
//   A+B or A-B (A + ~B + 1) through LATENCY pipeline stages, queues results
//   in an OUT_DEPTH-entry FIFO and broadcasts the head on the CDB under grant.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready         op handshake from the reservation station
//   in_op                     0 = add, 1 = subtract
//   in_a, in_b, in_tag        operands and destination tag
//   cdb_req/cdb_grant         CDB request (queue non-empty) and arbiter grant
//   cdb_tag, cdb_data         head result, held 0 while cdb_req = 0
//   cdb_cout, cdb_ovf         head carry-out / signed overflow
//
// Configuration:
//   ADDSUB_FLAGS_EN  when defined, cout/ovf are computed and carried to the
//                    CDB; when undefined, flag storage is dropped and
//                    cdb_cout/cdb_ovf are tied to 0.
module addsub_exec_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             cdb_req,
  input  logic             cdb_grant,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_cout,
  output logic             cdb_ovf
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(OUT_DEPTH + LATENCY + 1);
`ifdef ADDSUB_FLAGS_EN
  localparam int unsigned SUM_W = WIDTH + 1;
`else
  localparam int unsigned SUM_W = WIDTH;
`endif

  // Result payload carried through the pipeline and the queue.
  typedef struct packed {
`ifdef ADDSUB_FLAGS_EN
    logic             cout;
    logic             ovf;
`endif
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] data;
  } res_t;

  logic [LATENCY-1:0] stg_vld_q, stg_vld_d;
  res_t               stg_q [LATENCY];
  res_t               stg_d [LATENCY];
  res_t               q_mem_q [OUT_DEPTH];
  res_t               q_mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               in_ready_q, in_ready_d;
  logic               cdb_req_q, cdb_req_d;
  res_t               cdb_head_q, cdb_head_d;

  logic [WIDTH-1:0]   b_eff;
  logic [SUM_W-1:0]   sum;
  res_t               new_res;
  logic               accept;
  logic               push;
  logic               pop;
  logic [OCC_W-1:0]   inflight_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state: arithmetic, pipeline shift, FIFO and credit accounting.
  always_comb begin
    b_eff   = in_op ? ~in_b : in_b;
    sum     = SUM_W'(in_a) + SUM_W'(b_eff) + SUM_W'(in_op);
    new_res = '0;
    new_res.tag  = in_tag;
    new_res.data = sum[WIDTH-1:0];
`ifdef ADDSUB_FLAGS_EN
    new_res.cout = sum[WIDTH];
    new_res.ovf  = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
`endif

    accept = in_valid && in_ready_q;
    push   = stg_vld_q[LATENCY-1];
    pop    = cdb_req_q && cdb_grant;

    // Stages always advance; credits guarantee room in the queue.
    stg_vld_d    = '0;
    stg_d        = stg_q;
    stg_vld_d[0] = accept;
    stg_d[0]     = new_res;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stg_vld_d[i] = stg_vld_q[i-1];
      stg_d[i]     = stg_q[i-1];
    end

    q_mem_d  = q_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = stg_q[LATENCY-1];
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Credit check on the state the next cycle will see.
    inflight_d = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight_d = inflight_d + OCC_W'(stg_vld_d[i]);
    end
    in_ready_d = (OCC_W'(count_d) + inflight_d) < OCC_W'(OUT_DEPTH);

    // Registered CDB head; zeroed whenever the queue is empty.
    cdb_req_d  = (count_d != '0);
    cdb_head_d = cdb_req_d ? q_mem_d[rd_ptr_d] : '0;
  end

  // State registers; payload storage needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_vld_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      cdb_req_q  <= 1'b0;
      cdb_head_q <= '0;
    end else begin
      stg_vld_q  <= stg_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      cdb_req_q  <= cdb_req_d;
      cdb_head_q <= cdb_head_d;
    end
    stg_q   <= stg_d;
    q_mem_q <= q_mem_d;
  end

  assign in_ready = in_ready_q;
  assign cdb_req  = cdb_req_q;
  assign cdb_tag  = cdb_head_q.tag;
  assign cdb_data = cdb_head_q.data;
`ifdef ADDSUB_FLAGS_EN
  assign cdb_cout = cdb_head_q.cout;
  assign cdb_ovf  = cdb_head_q.ovf;
`else
  assign cdb_cout = 1'b0;
  assign cdb_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_exec_unit.sv
// Self-checking bench for addsub_exec_unit (default parameters).
module tb_addsub_exec_unit;

`ifdef ADDSUB_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        cdb_req;
  logic        cdb_grant;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        cdb_cout;
  logic        cdb_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  addsub_exec_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .cdb_req   (cdb_req),
    .cdb_grant (cdb_grant),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_cout  (cdb_cout),
    .cdb_ovf   (cdb_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] data;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the next broadcast and checks its tag.
  task automatic expect_broadcast(input string name, input logic [3:0] exp_tag);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (cdb_req) begin
        found = 1'b1;
        check(name, 64'(cdb_tag), 64'(exp_tag));
      end
      step();
    end
    check({name, " seen"}, 64'(found), 64'd1);
  endtask

  // Single op on an idle unit with grant held: latency, result and drain.
  task automatic run_vec(input int idx, input vec_t v);
    string nm;
    nm = $sformatf("vec%0d", idx);
    in_valid = 1'b1;
    in_op    = v.op;
    in_a     = v.a;
    in_b     = v.b;
    in_tag   = v.tag;
    check({nm, " ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check({nm, " req+0"}, 64'(cdb_req), 64'd0);
    step();
    check({nm, " req+1"}, 64'(cdb_req), 64'd0);
    step();
    check({nm, " req+2"}, 64'(cdb_req), 64'd1);
    check({nm, " data"}, 64'(cdb_data), 64'(v.data));
    check({nm, " tag"}, 64'(cdb_tag), 64'(v.tag));
    check({nm, " cout"}, 64'(cdb_cout), 64'(v.cout & FLAGS_ON));
    check({nm, " ovf"}, 64'(cdb_ovf), 64'(v.ovf & FLAGS_ON));
    step();
    check({nm, " drained"}, 64'(cdb_req), 64'd0);
    check({nm, " data0"}, 64'(cdb_data), 64'd0);
  endtask

  initial begin
    int          next_tag;
    int          n_rx;
    logic [3:0]  rx_tag [8];
    logic [31:0] rx_data [8];
    logic        acc;

    vecs[0] = '{1'b0, 32'h0000_0009, 32'hFFFF_FFFC, 4'd3, 32'h0000_0005, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h0000_0009, 4'd5, 32'hFFFF_FFFB, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0009, 32'h0000_0004, 4'd6, 32'h0000_0005, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 4'd7, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 4'd8, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0005, 32'h0000_0005, 4'd9, 32'h0000_0000, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'hFFFF_FFFE, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 4'd15, 32'h0000_0000, 1'b1, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    cdb_grant = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst cdb_req", 64'(cdb_req), 64'd0);
    check("rst cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst cdb_data", 64'(cdb_data), 64'd0);
    check("rst cdb_cout", 64'(cdb_cout), 64'd0);
    check("rst cdb_ovf", 64'(cdb_ovf), 64'd0);

    // Arithmetic vectors (grant held high, also covers spurious grant when empty)
    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: grant low, valid held with tags 1,2,3
    cdb_grant = 1'b0;
    in_valid  = 1'b1;
    in_op     = 1'b0;
    in_a      = 32'd1;
    in_b      = 32'd1;
    in_tag    = 4'd1;
    check("bp ready t1", 64'(in_ready), 64'd1);
    step();
    check("bp ready t2", 64'(in_ready), 64'd1);
    in_tag = 4'd2;
    step();
    check("bp full e1", 64'(in_ready), 64'd0);
    in_tag = 4'd3;
    step();
    check("bp req e2", 64'(cdb_req), 64'd1);
    check("bp head e2", 64'(cdb_tag), 64'd1);
    check("bp data e2", 64'(cdb_data), 64'd2);
    check("bp full e2", 64'(in_ready), 64'd0);
    step();
    step();
    check("bp full e4", 64'(in_ready), 64'd0);
    check("bp head e4", 64'(cdb_tag), 64'd1);
    cdb_grant = 1'b1;
    step();
    cdb_grant = 1'b0;
    check("bp head after pop", 64'(cdb_tag), 64'd2);
    check("bp req after pop", 64'(cdb_req), 64'd1);
    check("bp ready after pop", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp full after t3", 64'(in_ready), 64'd0);
    check("bp head hold", 64'(cdb_tag), 64'd2);
    cdb_grant = 1'b1;
    expect_broadcast("bp order 2", 4'd2);
    expect_broadcast("bp order 3", 4'd3);
    check("bp empty", 64'(cdb_req), 64'd0);
    check("bp ready empty", 64'(in_ready), 64'd1);

    // Reset mid-operation; in_valid stays high across the reset edge
    in_valid = 1'b1;
    in_tag   = 4'd7;
    step();
    in_tag = 4'd8;
    step();
    in_tag = 4'd9;
    rst    = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rmid in_ready", 64'(in_ready), 64'd1);
    check("rmid cdb_req", 64'(cdb_req), 64'd0);
    check("rmid cdb_tag", 64'(cdb_tag), 64'd0);
    check("rmid cdb_data", 64'(cdb_data), 64'd0);
    check("rmid cdb_cout", 64'(cdb_cout), 64'd0);
    check("rmid cdb_ovf", 64'(cdb_ovf), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rmid quiet %0d", i), 64'(cdb_req), 64'd0);
    end

    // Streaming: valid offered every cycle, grant high, 8 ops
    next_tag = 0;
    n_rx     = 0;
    for (int cyc = 0; cyc < 100 && n_rx < 8; cyc++) begin
      if (cdb_req) begin
        rx_tag[n_rx]  = cdb_tag;
        rx_data[n_rx] = cdb_data;
        n_rx++;
      end
      in_valid = (next_tag < 8);
      in_op    = 1'b0;
      in_tag   = 4'(next_tag);
      in_a     = 32'(next_tag);
      in_b     = 32'd100;
      acc      = in_valid && in_ready;
      step();
      if (acc) next_tag++;
    end
    in_valid = 1'b0;
    check("stream count", 64'(n_rx), 64'd8);
    for (int i = 0; i < n_rx; i++) begin
      check($sformatf("stream tag %0d", i), 64'(rx_tag[i]), 64'(i));
      check($sformatf("stream data %0d", i), 64'(rx_data[i]), 64'(i + 100));
    end
    step();
    check("stream drained", 64'(cdb_req), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
